// File: rtl/ysyx_22050078_wb_queue.sv
// Writeback queue: buffers (rd, data) results and drains one per cycle onto the
// register file write port, with youngest-match forwarding for rs1/rs2.
module ysyx_22050078_wb_queue #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [ADDR_WIDTH-1:0]        in_addr,
   input  logic [DATA_WIDTH-1:0]        in_data,
   input  logic                         wb_stall,
   output logic                         w_en,
   output logic [ADDR_WIDTH-1:0]        wr_addr,
   output logic [DATA_WIDTH-1:0]        wr_data,
   input  logic [ADDR_WIDTH-1:0]        rs1_addr,
   input  logic [ADDR_WIDTH-1:0]        rs2_addr,
   output logic                         fwd1_hit,
   output logic [DATA_WIDTH-1:0]        fwd1_data,
   output logic                         fwd2_hit,
   output logic [DATA_WIDTH-1:0]        fwd2_data,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
   logic [DATA_WIDTH-1:0] data_q [DEPTH];
   logic [PW-1:0]         head;
   logic [PW-1:0]         tail;
   logic                  push;
   logic                  store;
   logic                  pop;
   logic                  not_empty;

   assign not_empty = (count != '0);
   assign in_ready  = (count != FULL);
   assign push      = in_valid & in_ready;
   // Writes to x0 complete the handshake but never occupy an entry.
   assign store     = push & (in_addr != '0);
   assign w_en      = not_empty & ~wb_stall;
   assign pop       = w_en;
   assign wr_addr   = not_empty ? addr_q[head] : '0;
   assign wr_data   = not_empty ? data_q[head] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (store) tail <= tail + PW'(1);
         if (pop)   head <= head + PW'(1);
         case ({store, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (store) begin
         addr_q[tail] <= in_addr;
         data_q[tail] <= in_data;
      end
   end

   // Scan oldest to youngest so the last match (youngest) wins.
   always_comb begin
      logic [PW-1:0] idx;
      idx       = '0;
      fwd1_hit  = 1'b0;
      fwd1_data = '0;
      fwd2_hit  = 1'b0;
      fwd2_data = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = head + PW'(i);
         if (CW'(i) < count) begin
            if ((rs1_addr != '0) && (addr_q[idx] == rs1_addr)) begin
               fwd1_hit  = 1'b1;
               fwd1_data = data_q[idx];
            end
            if ((rs2_addr != '0) && (addr_q[idx] == rs2_addr)) begin
               fwd2_hit  = 1'b1;
               fwd2_data = data_q[idx];
            end
         end
      end
   end

endmodule

// File: tb/tb_ysyx_22050078_wb_queue.sv
// Scoreboard bench for the writeback queue: stimulus pushes expected writes,
// a negedge monitor checks every register file write in order.
module tb_ysyx_22050078_wb_queue;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_addr;
   logic [63:0] in_data;
   logic        wb_stall;
   logic        w_en;
   logic [4:0]  wr_addr;
   logic [63:0] wr_data;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic        fwd1_hit;
   logic [63:0] fwd1_data;
   logic        fwd2_hit;
   logic [63:0] fwd2_data;
   logic [2:0]  count;

   int n_cmp = 0;
   int n_err = 0;
   logic [68:0] exp_q [$];

   ysyx_22050078_wb_queue #(.ADDR_WIDTH(5), .DATA_WIDTH(64), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
      .wb_stall(wb_stall), .w_en(w_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
      .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
      .count(count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every register file write must match the oldest expected entry.
   always @(negedge clk) begin
      if (rst_n && w_en) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write", {wr_addr, wr_data}, '0);
         end else begin
            chk("wb_order", {wr_addr, wr_data}, exp_q.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [4:0] a, input logic [63:0] d);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_addr  = a;
      in_data  = d;
      while (!in_ready && n < 50) begin
         step();
         n++;
      end
      if (!in_ready) begin
         chk("push_timeout", 69'(in_ready), 69'(1));
      end else begin
         if (a != 5'd0) exp_q.push_back({a, d});
         step();
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      wb_stall = 1'b0;
      while (count != 3'd0 && n < 50) begin
         step();
         n++;
      end
      chk("drain_count", 69'(count), 69'(0));
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
      wb_stall = 1'b0; rs1_addr = '0; rs2_addr = '0;
      #12;
      chk("rst_count", 69'(count), 69'(0));
      chk("rst_ready", 69'(in_ready), 69'(1));
      chk("rst_wen", {w_en, wr_addr, wr_data[62:0]}, '0);
      chk("rst_fwd", {fwd1_hit, fwd2_hit, fwd1_data[33:0], fwd2_data[32:0]}, '0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      step();

      // Single write, one-cycle latency
      push(5'd5, 64'hAA);
      #2;
      chk("t1_wen", 69'(w_en), 69'(1));
      chk("t1_wr", {wr_addr, wr_data}, {5'd5, 64'hAA});
      chk("t1_count1", 69'(count), 69'(1));
      step();
      chk("t1_count0", 69'(count), 69'(0));
      chk("t1_wen0", 69'(w_en), 69'(0));

      // Fill under stall, hold fifth request, then drain in order
      wb_stall = 1'b1;
      for (int i = 1; i <= 4; i++) push(5'(i), 64'h100 + 64'(i));
      chk("t2_full", 69'(count), 69'(4));
      chk("t2_ready0", 69'(in_ready), 69'(0));
      in_valid = 1'b1; in_addr = 5'd5; in_data = 64'h555;
      step(); step();
      chk("t2_held", 69'(count), 69'(4));
      exp_q.push_back({5'd5, 64'h555});
      wb_stall = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #2;
         chk("t2_wen_run", 69'(w_en), 69'(1));
         step();
         if (k == 1) in_valid = 1'b0;
      end
      chk("t2_empty", 69'(count), 69'(0));

      // Forwarding returns youngest match, x0 never hits
      wb_stall = 1'b1;
      push(5'd7, 64'h11);
      push(5'd7, 64'h22);
      rs1_addr = 5'd7; rs2_addr = 5'd0;
      #1;
      chk("t3_fwd1", {fwd1_hit, fwd1_data}, {1'b1, 64'h22});
      chk("t3_fwd2", {fwd2_hit, fwd2_data}, {1'b0, 64'h0});
      rs2_addr = 5'd9;
      #1;
      chk("t3_fwd2_miss", {fwd2_hit, fwd2_data}, {1'b0, 64'h0});
      rs1_addr = '0; rs2_addr = '0;
      drain();

      // Write to x0 is accepted but dropped
      chk("t4_ready", 69'(in_ready), 69'(1));
      push(5'd0, 64'hFF);
      chk("t4_count", 69'(count), 69'(0));
      chk("t4_wen", 69'(w_en), 69'(0));

      // Steady push+pop at count=2 across pointer wrap
      wb_stall = 1'b1;
      push(5'd10, 64'hA0);
      push(5'd11, 64'hA1);
      wb_stall = 1'b0;
      for (int i = 0; i < 10; i++) begin
         push(5'(12 + i), 64'hB0 + 64'(i));
         chk("t5_count", 69'(count), 69'(2));
      end
      drain();

      // Asynchronous reset mid-operation discards pending writes
      wb_stall = 1'b1;
      push(5'd8, 64'hC8);
      push(5'd9, 64'hC9);
      push(5'd10, 64'hCA);
      chk("t6_count3", 69'(count), 69'(3));
      rs1_addr = 5'd9;
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_count", 69'(count), 69'(0));
      chk("t6_rst_wen", 69'(w_en), 69'(0));
      chk("t6_rst_ready", 69'(in_ready), 69'(1));
      chk("t6_rst_fwd", 69'(fwd1_hit), 69'(0));
      exp_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      wb_stall = 1'b0;
      rs1_addr = '0;
      repeat (5) step();
      chk("t6_after", 69'(count), 69'(0));

      chk("sb_empty", 69'(exp_q.size()), 69'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
